calc_operand_feeder: RTL and testbench

- Initiator side of the dot-product calculation engine.
- Accepts a byte stream over a valid/ready handshake and packs 16 bytes into the 128-bit A operand, then 16 bytes into the 128-bit B operand.
- Presents both operands, stable, to the calculation engine, waits a fixed latency, captures the 20-bit reduction result and returns it over a valid/ready output handshake.
- Sits between the host/DMA byte interface and the calculation array.

---
 rtl/calc_operand_feeder_if.sv | 30 +++
 rtl/calc_operand_feeder.sv | 110 +++++++++++
 tb/tb_calc_operand_feeder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_operand_feeder_if.sv
// Handshake and operand bundle between the byte source, the operand feeder and the calculation engine.
// The slave modport is the feeder's view. The master modport is the surrounding system's view.
interface calc_operand_feeder_if #(
    parameter int DATA_W = 8,
    parameter int VEC_W  = 128,
    parameter int RES_W  = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [VEC_W-1:0]  calc_A;
    logic [VEC_W-1:0]  calc_B;
    logic              calc_go;
    logic [RES_W-1:0]  calc_result;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              busy;
    logic [15:0]       jobs_done;

    modport master (
        output in_valid, in_data, calc_result, out_ready,
        input  in_ready, calc_A, calc_B, calc_go, out_valid, out_data, busy, jobs_done
    );

    modport slave (
        input  in_valid, in_data, calc_result, out_ready,
        output in_ready, calc_A, calc_B, calc_go, out_valid, out_data, busy, jobs_done
    );
endinterface

// File: rtl/calc_operand_feeder.sv
// Packs a byte stream into the A and B operands and issues one calculation.
// It captures the result after a fixed latency and returns it over a valid/ready handshake.
module calc_operand_feeder #(
    parameter int DATA_W   = 8,
    parameter int VEC_W    = 128,
    parameter int RES_W    = 20,
    parameter int CALC_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_operand_feeder_if.slave bus
);
    localparam int N_BYTES = VEC_W / DATA_W;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [VEC_W-1:0]   r_calc_a;
    logic [VEC_W-1:0]   r_calc_b;
    logic               r_calc_go;
    logic               r_out_valid;
    logic [RES_W-1:0]   r_out_data;
    logic [15:0]        r_jobs_done;

    logic               w_in_ready;
    logic               w_xfer;
    logic               w_last_byte;

    // in_ready is decoded from state so a stalled source never loses a byte.
    assign w_in_ready  = !rst && ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B));
    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_last_byte = (r_idx == IDX_W'(N_BYTES - 1));

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD_A;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_calc_a    <= '0;
            r_calc_b    <= '0;
            r_calc_go   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_jobs_done <= '0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_xfer) begin
                        r_calc_a[int'(r_idx)*DATA_W +: DATA_W] <= bus.in_data;
                        r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
                        if (w_last_byte) r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_xfer) begin
                        r_calc_b[int'(r_idx)*DATA_W +: DATA_W] <= bus.in_data;
                        r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
                        if (w_last_byte) begin
                            r_calc_go <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_calc_go <= 1'b0;
                    r_cnt     <= CNT_W'(1);
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // r_cnt equals the number of cycles elapsed since calc_go.
                    if (r_cnt == CNT_W'(CALC_LAT)) begin
                        r_out_data  <= bus.calc_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= ST_LOAD_A;
                    end
                end
                default: r_state <= ST_LOAD_A;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.calc_A    = r_calc_a;
    assign bus.calc_B    = r_calc_b;
    assign bus.calc_go   = r_calc_go;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.jobs_done = r_jobs_done;
    assign bus.busy      = !((r_state == ST_LOAD_A) && (r_idx == '0));
endmodule

// File: tb/tb_calc_operand_feeder.sv
// Table-driven bench. It runs three feeders (latencies 3, 1 and 15) from one shared byte stream.
// Each feeder has an engine model that presents the correct result only on the intended capture cycle.
module tb_calc_operand_feeder;
    typedef struct {
        logic [7:0]   a0;
        logic [7:0]   a_step;
        logic [7:0]   b0;
        logic [7:0]   b_step;
        bit           throttle;
        int           hold;
        bit           pre_reset;
        bit           pre_force;
        logic [19:0]  result;
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        logic [15:0]  exp_jobs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_in_valid = 1'b0;
    logic [7:0]  tb_in_data = 8'h00;
    logic        tb_out_ready = 1'b1;
    logic [19:0] cur_result = 20'h0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          go_cnt, go_cyc;
    int          l1_go, l1_val, l15_go, l15_val;
    logic [19:0] l1_data, l15_data;
    logic        l1_pv = 1'b0, l15_pv = 1'b0;
    logic [4:0]  km = '0, k1 = '0, k15 = '0;
    vec_t        vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_operand_feeder_if bus_m ();
    calc_operand_feeder_if bus_l1 ();
    calc_operand_feeder_if bus_l15 ();

    calc_operand_feeder #(.CALC_LAT(3))  dut_m   (.clk(clk), .rst(rst), .bus(bus_m));
    calc_operand_feeder #(.CALC_LAT(1))  dut_l1  (.clk(clk), .rst(rst), .bus(bus_l1));
    calc_operand_feeder #(.CALC_LAT(15)) dut_l15 (.clk(clk), .rst(rst), .bus(bus_l15));

    assign bus_m.in_valid    = tb_in_valid;
    assign bus_l1.in_valid   = tb_in_valid;
    assign bus_l15.in_valid  = tb_in_valid;
    assign bus_m.in_data     = tb_in_data;
    assign bus_l1.in_data    = tb_in_data;
    assign bus_l15.in_data   = tb_in_data;
    assign bus_m.out_ready   = tb_out_ready;
    assign bus_l1.out_ready  = tb_out_ready;
    assign bus_l15.out_ready = tb_out_ready;

    // Engine model: the result is correct only k == latency cycles after calc_go, and differs in bit 19 otherwise.
    function automatic logic [19:0] engine(logic [4:0] k, int lat);
        return (int'(k) == lat) ? cur_result : (cur_result ^ 20'h80000 ^ 20'(k));
    endfunction

    always @(posedge clk) begin
        km  <= bus_m.calc_go   ? 5'd1 : ((km  != 0 && km  < 31) ? km  + 5'd1 : 5'd0);
        k1  <= bus_l1.calc_go  ? 5'd1 : ((k1  != 0 && k1  < 31) ? k1  + 5'd1 : 5'd0);
        k15 <= bus_l15.calc_go ? 5'd1 : ((k15 != 0 && k15 < 31) ? k15 + 5'd1 : 5'd0);
    end
    assign bus_m.calc_result   = engine(km, 3);
    assign bus_l1.calc_result  = engine(k1, 1);
    assign bus_l15.calc_result = engine(k15, 15);

    always @(negedge clk) begin
        if (bus_l1.calc_go) l1_go = cyc;
        if (bus_l1.out_valid && !l1_pv) begin
            l1_val  = cyc;
            l1_data = bus_l1.out_data;
        end
        l1_pv = bus_l1.out_valid;
        if (bus_l15.calc_go) l15_go = cyc;
        if (bus_l15.out_valid && !l15_pv) begin
            l15_val  = cyc;
            l15_data = bus_l15.out_data;
        end
        l15_pv = bus_l15.out_valid;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample_go();
        if (bus_m.calc_go) begin
            go_cnt++;
            go_cyc = cyc;
        end
    endtask

    function automatic logic [7:0] byte_at(vec_t v, int n);
        if (n < 16) return 8'(int'(v.a0) + int'(v.a_step) * n);
        return 8'(int'(v.b0) + int'(v.b_step) * (n - 16));
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_zero_ops"}, {bus_m.calc_A | bus_m.calc_B}, 128'h0);
        check({tag, "_zero_ctl"}, {bus_m.calc_go, bus_m.out_valid, bus_m.out_data, bus_m.jobs_done}, '0);
        check({tag, "_in_ready_low"}, 128'(bus_m.in_ready), 128'h0);
        check({tag, "_idle"}, 128'(bus_m.busy), 128'h0);
    endtask

    task automatic run_job(input vec_t v);
        int n;
        int last_cyc;
        cur_result   = v.result;
        tb_out_ready = (v.hold == 0);
        go_cnt = 0; go_cyc = -100; last_cyc = -100;
        l1_go = -100; l1_val = -1; l15_go = -100; l15_val = -1;

        if (v.pre_reset) begin
            // Partial job: all of A (0x55) plus five B bytes (0x66), then reset.
            n = 0;
            for (int c = 0; c < 100 && n < 21; c++) begin
                @(negedge clk);
                tb_in_valid = 1'b1;
                tb_in_data  = (n < 16) ? 8'h55 : 8'h66;
                if (bus_m.in_ready) n++;
            end
            @(negedge clk);
            tb_in_valid = 1'b0;
            check("pre_reset_busy", 128'(bus_m.busy), 128'h1);
            rst = 1'b1;
            @(negedge clk);
            check_reset_state("midrst");
            rst = 1'b0;
            @(negedge clk);
            check("midrst_ready_back", 128'(bus_m.in_ready), 128'h1);
        end

        if (v.pre_force) begin
            @(negedge clk);
            force dut_m.r_jobs_done = 16'hFFFF;
            #1 release dut_m.r_jobs_done;
            check("force_preload", 128'(bus_m.jobs_done), 128'hFFFF);
        end

        n = 0;
        for (int c = 0; c < 200 && n < 32; c++) begin
            @(negedge clk);
            sample_go();
            tb_in_valid = !(v.throttle && c[0]);
            tb_in_data  = byte_at(v, n);
            if (tb_in_valid && bus_m.in_ready) begin
                n++;
                last_cyc = cyc;
            end
        end
        check("transfers", 128'(n), 128'd32);

        // The source offers one more byte while the feeder sits in ISSUE. That byte must be refused.
        @(negedge clk);
        tb_in_valid = 1'b1;
        tb_in_data  = 8'hEE;
        sample_go();
        check("no_extra_byte", 128'(bus_m.in_ready), 128'h0);

        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            tb_in_valid = 1'b0;
            sample_go();
            if (bus_m.out_valid) break;
        end
        check("out_valid_rise", 128'(bus_m.out_valid), 128'h1);
        check("go_after_last_byte", 128'(go_cyc - last_cyc), 128'd1);
        check("valid_after_go", 128'(cyc - go_cyc), 128'd4);
        check("out_data", 128'(bus_m.out_data), 128'(v.result));
        check("calc_A", bus_m.calc_A, v.exp_a);
        check("calc_B", bus_m.calc_B, v.exp_b);
        check("out_state", {bus_m.in_ready, bus_m.busy}, 128'b01);

        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            sample_go();
            check("bp_hold", {bus_m.out_valid, bus_m.in_ready, bus_m.out_data}, {1'b1, 1'b0, v.result});
            check("bp_calc_A", bus_m.calc_A, v.exp_a);
            check("bp_calc_B", bus_m.calc_B, v.exp_b);
        end
        tb_out_ready = 1'b1;

        @(negedge clk);
        sample_go();
        check("handshake_valid_low", 128'(bus_m.out_valid), 128'h0);
        check("jobs_done", 128'(bus_m.jobs_done), 128'(v.exp_jobs));
        check("ready_after_hs", {bus_m.in_ready, bus_m.busy}, 128'b10);
        check("go_pulses", 128'(go_cnt), 128'd1);

        for (int c = 0; c < 64; c++) begin
            if (!bus_l1.busy && !bus_l15.busy && !bus_l1.out_valid && !bus_l15.out_valid) break;
            @(negedge clk);
        end
        check("lat1_delay", 128'(l1_val - l1_go), 128'd2);
        check("lat1_data", 128'(l1_data), 128'(v.result));
        check("lat15_delay", 128'(l15_val - l15_go), 128'd16);
        check("lat15_data", 128'(l15_data), 128'(v.result));
    endtask

    initial begin
        //          a0     astep  b0     bstep  thr hold rst frc result
        vecs[0] = '{8'h01, 8'h00, 8'h02, 8'h00, 0, 0,  0,  0,  20'h12345,
                    {16{8'h01}}, {16{8'h02}}, 16'd1};
        vecs[1] = '{8'h00, 8'h01, 8'h10, 8'h01, 1, 0,  0,  0,  20'hABCDE,
                    128'h0F0E0D0C0B0A09080706050403020100,
                    128'h1F1E1D1C1B1A19181716151413121110, 16'd2};
        vecs[2] = '{8'hF0, 8'h01, 8'h80, 8'h03, 0, 10, 0,  0,  20'h0F00D,
                    128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0,
                    128'hADAAA7A4A19E9B9895928F8C89868380, 16'd3};
        vecs[3] = '{8'h20, 8'h02, 8'hC3, 8'h00, 0, 0,  1,  0,  20'h55AA5,
                    128'h3E3C3A38363432302E2C2A2826242220,
                    {16{8'hC3}}, 16'd1};
        vecs[4] = '{8'hA5, 8'h00, 8'h5A, 8'h00, 0, 0,  0,  1,  20'hFFFFF,
                    {16{8'hA5}}, {16{8'h5A}}, 16'h0000};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {bus_m.in_ready, bus_m.busy}, 128'b10);

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
